// File: rtl/map_trellis_step_counter_if.sv
// Control and status bundle for the MAP trellis step sequencer.
// The master drives the frame controls; the slave is the sequencer itself.
interface map_trellis_step_counter_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic [CNT_W-1:0] frame_len;
   logic             stall;
   logic             clear;
   logic [CNT_W-1:0] count;
   logic [2:0]       phase;
   logic             valid;
   logic             busy;
   logic             phase_done;
   logic             frame_done;

   modport master (
      output start, frame_len, stall, clear,
      input  count, phase, valid, busy, phase_done, frame_done
   );

   modport slave (
      input  start, frame_len, stall, clear,
      output count, phase, valid, busy, phase_done, frame_done
   );
endinterface

// File: rtl/map_trellis_step_counter.sv
// Frame sequencer for the MAP decoder: GAMMA, ALPHA, BETA, LLR, each L steps,
// with per-phase direction, stall hold, synchronous abort and completion pulses.
module map_trellis_step_counter #(
   parameter int CNT_W     = 8,
   parameter bit BETA_DOWN = 1'b1,
   parameter bit LLR_DOWN  = 1'b0
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   map_trellis_step_counter_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GAMMA = 3'd1,
      ST_ALPHA = 3'd2,
      ST_BETA  = 3'd3,
      ST_LLR   = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             phase_done_q, phase_done_d;
   logic             frame_done_q, frame_done_d;

   function automatic logic is_down(state_e st);
      case (st)
         ST_BETA: return BETA_DOWN;
         ST_LLR:  return LLR_DOWN;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] start_val(state_e st, logic [CNT_W-1:0] len);
      return is_down(st) ? (len - ONE) : ZERO;
   endfunction

   function automatic logic [CNT_W-1:0] term_val(state_e st, logic [CNT_W-1:0] len);
      return is_down(st) ? ZERO : (len - ONE);
   endfunction

   function automatic state_e next_phase(state_e st);
      case (st)
         ST_GAMMA: return ST_ALPHA;
         ST_ALPHA: return ST_BETA;
         ST_BETA:  return ST_LLR;
         default:  return ST_DONE;
      endcase
   endfunction

   // Next-state and next-output logic; pulses default low so they last one cycle.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      len_d        = len_q;
      valid_d      = valid_q;
      busy_d       = busy_q;
      phase_done_d = 1'b0;
      frame_done_d = 1'b0;
      if (bus.clear) begin
         state_d = ST_IDLE;
         count_d = ZERO;
         valid_d = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start && (bus.frame_len != ZERO)) begin
                  len_d   = bus.frame_len;
                  state_d = ST_GAMMA;
                  count_d = ZERO;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  count_d = ZERO;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
               end
            end
            ST_GAMMA, ST_ALPHA, ST_BETA, ST_LLR: begin
               if (bus.stall) begin
                  state_d = state_q;
                  count_d = count_q;
               end else if (count_q == term_val(state_q, len_q)) begin
                  phase_done_d = 1'b1;
                  if (state_q == ST_LLR) begin
                     state_d      = ST_DONE;
                     count_d      = ZERO;
                     valid_d      = 1'b0;
                     frame_done_d = 1'b1;
                  end else begin
                     state_d = next_phase(state_q);
                     count_d = start_val(next_phase(state_q), len_q);
                  end
               end else if (is_down(state_q)) begin
                  count_d = count_q - ONE;
               end else begin
                  count_d = count_q + ONE;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               count_d = ZERO;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
               count_d = ZERO;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         count_q      <= ZERO;
         len_q        <= ZERO;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         phase_done_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         len_q        <= len_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
         phase_done_q <= phase_done_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.count      = count_q;
   assign bus.phase      = state_q;
   assign bus.valid      = valid_q;
   assign bus.busy       = busy_q;
   assign bus.phase_done = phase_done_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_map_trellis_step_counter.sv
// Bench for map_trellis_step_counter: directed frames plus randomized stall/start
// traffic, each cycle compared against a per-frame expected step list.
module tb_map_trellis_step_counter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   map_trellis_step_counter_if #(.CNT_W(8)) ifa ();
   map_trellis_step_counter_if #(.CNT_W(4)) ifb ();

   map_trellis_step_counter #(.CNT_W(8), .BETA_DOWN(1'b1), .LLR_DOWN(1'b0)) dut_a (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (ifa.slave)
   );

   map_trellis_step_counter #(.CNT_W(4), .BETA_DOWN(1'b0), .LLR_DOWN(1'b1)) dut_b (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (ifb.slave)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // {phase[2:0], count[7:0], valid, busy, phase_done, frame_done}
   typedef logic [14:0] obs_t;

   function automatic obs_t mk(int ph, int cnt, bit v, bit b, bit pd, bit fd);
      return {3'(ph), 8'(cnt), v, b, pd, fd};
   endfunction

   function automatic obs_t observe(int sel);
      if (sel == 0)
         return {ifa.phase, ifa.count, ifa.valid, ifa.busy, ifa.phase_done, ifa.frame_done};
      else
         return {ifb.phase, 4'd0, ifb.count, ifb.valid, ifb.busy, ifb.phase_done, ifb.frame_done};
   endfunction

   task automatic check(string tag, obs_t obs, obs_t exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_int(string tag, int obs, int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(int sel, bit st, int len, bit sl, bit cl);
      if (sel == 0) begin
         ifa.start = st; ifa.frame_len = 8'(len); ifa.stall = sl; ifa.clear = cl;
      end else begin
         ifb.start = st; ifb.frame_len = 4'(len); ifb.stall = sl; ifb.clear = cl;
      end
   endtask

   // Expected stall-free trace of one frame: four phases of L steps, DONE, then IDLE.
   task automatic build(int len, bit bd, bit ld, output obs_t q[$]);
      q = {};
      for (int p = 1; p <= 4; p++) begin
         bit down = (p == 3) ? bd : ((p == 4) ? ld : 1'b0);
         for (int i = 0; i < len; i++)
            q.push_back(mk(p, down ? (len - 1 - i) : i, 1'b1, 1'b1, (p > 1) && (i == 0), 1'b0));
      end
      q.push_back(mk(5, 0, 1'b0, 1'b1, 1'b1, 1'b1));
      q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
   endtask

   // mode 0: clean; 1: random stall/start/frame_len; 2: stall ALPHA count 2 for 3 cycles;
   // 3: clear with stall at BETA count 1.
   task automatic run_frame(int sel, int len, int mode, output int fd_cycle);
      obs_t q[$];
      obs_t cur;
      obs_t idle_e;
      int   idx, cyc, stall_used;
      bit   st, cl, sn, fin;
      logic [2:0] ph;
      logic [7:0] cn;
      build(len, (sel == 0), (sel != 0), q);
      idle_e = q[q.size()-1];
      @(negedge clk);
      drive(sel, 1'b1, len, 1'b0, 1'b0);
      @(negedge clk);
      drive(sel, 1'b0, 0, 1'b0, 1'b0);
      cyc = 1; idx = 0; cur = q[0]; fd_cycle = -1; stall_used = 0; fin = 1'b0;
      while (!fin && cyc <= 5000) begin
         check($sformatf("dut%0d L=%0d mode=%0d cyc=%0d", sel, len, mode, cyc), observe(sel), cur);
         if (observe(sel)[0] === 1'b1 && fd_cycle < 0) fd_cycle = cyc;
         if (cur == idle_e) begin
            fin = 1'b1;
         end else begin
            ph = cur[14:12]; cn = cur[11:4];
            st = 1'b0; cl = 1'b0; sn = 1'b0;
            case (mode)
               1: begin
                  st = (ph >= 3'd1) && (ph <= 3'd4) && ($urandom_range(0, 3) == 0);
                  sn = 1'($urandom_range(0, 1));
               end
               2: if (ph == 3'd2 && cn == 8'd2 && stall_used < 3) begin st = 1'b1; stall_used++; end
               3: if (ph == 3'd3 && cn == 8'd1) begin st = 1'b1; cl = 1'b1; end
               default: ;
            endcase
            drive(sel, sn, int'($urandom), st, cl);
            @(negedge clk);
            cyc++;
            if (cl) cur = idle_e;
            else if (st) cur[1:0] = 2'b00;
            else begin idx++; cur = q[idx]; end
         end
      end
      n_assert++;
      assert (fin) else begin
         n_fail++;
         $error("FAIL timeout dut%0d L=%0d: observed %0d cycles expected completion", sel, len, cyc);
      end
      drive(sel, 1'b0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      int fd;
      obs_t idle_e;
      idle_e = mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(0, 1'b0, 0, 1'b0, 1'b0);
      drive(1, 1'b0, 0, 1'b0, 1'b0);

      #12;
      check("reset_a", observe(0), idle_e);
      check("reset_b", observe(1), idle_e);
      @(negedge clk);
      rst_n = 1'b1;

      run_frame(0, 4, 0, fd);
      check_int("fd_cycle_L4", fd, 17);
      run_frame(0, 4, 2, fd);
      check_int("fd_cycle_L4_stall", fd, 20);
      run_frame(0, 1, 0, fd);
      check_int("fd_cycle_L1", fd, 5);

      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive(0, 1'b1, 0, 1'b0, 1'b0);
         @(negedge clk);
         check($sformatf("zero_len_%0d", k), observe(0), idle_e);
      end
      drive(0, 1'b0, 0, 1'b0, 1'b0);

      run_frame(0, 4, 3, fd);
      check_int("clear_no_frame_done", fd, -1);

      @(negedge clk);
      drive(0, 1'b1, 4, 1'b0, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 0, 1'b0, 1'b0);
      repeat (13) @(negedge clk);
      check("pre_reset_llr", observe(0), mk(4, 1, 1'b1, 1'b1, 1'b0, 1'b0));
      #2 rst_n = 1'b0;
      #1 check("async_reset", observe(0), idle_e);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("post_reset_%0d", k), observe(0), idle_e);
      end

      run_frame(1, 15, 0, fd);
      check_int("fd_cycle_b_L15", fd, 61);
      run_frame(0, 255, 0, fd);
      check_int("fd_cycle_L255", fd, 1021);

      for (int k = 0; k < 6; k++) begin
         run_frame(0, int'($urandom_range(1, 12)), 1, fd);
         run_frame(1, int'($urandom_range(1, 15)), 1, fd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/map_trellis_step_counter.md
Name: map_trellis_step_counter

Overview:
- Parametrised trellis-step sequencer for the MAP decoder.
- For one frame it steps through four phases in fixed order: GAMMA, ALPHA, BETA, LLR.
- Each phase has its own count direction, a stall/hold input, and per-phase and end-of-frame completion pulses.
- It drives the address/step index for the branch-metric, forward, backward and LLR units. It replaces the single free-running step counter that had only a hold input.

Parameters:
- CNT_W, 8, width of the step counter and of frame_len.
- BETA_DOWN, 1, 1: BETA counts L-1 down to 0; 0: BETA counts 0 up to L-1.
- LLR_DOWN, 0, 1: LLR counts L-1 down to 0; 0: LLR counts 0 up to L-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  start a frame; sampled only in IDLE.
- frame_len  in  CNT_W  frame length L in trellis steps; latched on an accepted start.
- stall  in  1  hold: freezes the count and the state for that cycle.
- clear  in  1  synchronous abort; returns to IDLE.
- count  out  CNT_W  current step index.
- phase  out  3  0=IDLE, 1=GAMMA, 2=ALPHA, 3=BETA, 4=LLR, 5=DONE.
- valid  out  1  count is a live step (phases GAMMA..LLR).
- busy  out  1  state is not IDLE.
- phase_done  out  1  one-cycle pulse after the terminal step of a phase is consumed.
- frame_done  out  1  one-cycle pulse in the DONE state.

Behaviour:
- Registered outputs. The clock is clk; the reset is rst, asynchronous and active-low.
- Reset (rst=0), asynchronous: state=IDLE, count=0, phase=0, valid=0, busy=0, phase_done=0, frame_done=0, latched L=0.
- clear=1, synchronous, has the highest priority after reset:
  - next cycle: IDLE, count=0, all pulses 0;
  - it overrides stall and start.
- IDLE:
  - start=1 with frame_len!=0: latch L; next cycle GAMMA with count=0, valid=1, busy=1.
  - start with frame_len==0: ignored; stay IDLE.
- Counting phases (GAMMA, ALPHA, BETA, LLR):
  - Start value: 0 for an up phase, L-1 for a down phase.
  - Terminal value: L-1 for an up phase, 0 for a down phase.
  - GAMMA and ALPHA always count up.
  - stall=1: count, state and all outputs hold. phase_done=0 and frame_done=0 during a stall.
  - stall=0 and count not terminal: count steps by ±1. It never wraps.
  - stall=0 and count at terminal: next cycle enters the next phase at its start value, with phase_done=1 for that single cycle.
- Phase order: GAMMA -> ALPHA -> BETA -> LLR -> DONE.
- Steps per phase: each phase presents exactly L steps when there is no stall. L=1 gives one step per phase.
- DONE:
  - Lasts one cycle: valid=0, busy=1, frame_done=1, phase_done=1 (LLR completion), count=0.
  - Next cycle: IDLE.
- start while busy: ignored. A new frame may start in the IDLE cycle that follows DONE.
- Arithmetic: the count is unsigned CNT_W bits. L max = 2^CNT_W-1. Count never exceeds L-1.
- Reset mid-frame: abandons the frame immediately; no pulses are emitted.

Test Plan:
- L=4, start at cycle 0, no stall:
  - cycles 1-4 GAMMA count 0,1,2,3;
  - cycles 5-8 ALPHA 0..3;
  - cycles 9-12 BETA 3,2,1,0;
  - cycles 13-16 LLR 0..3;
  - phase_done at cycles 5, 9, 13, 17;
  - frame_done at cycle 17; IDLE at cycle 18.
- L=4, stall=1 at ALPHA count=2 for 3 cycles: count holds at 2 and phase=2 for 3 cycles; no pulses; the sequence then resumes; frame_done is delayed by 3 cycles (cycle 20).
- L=1: each phase shows count 0 for one cycle; phase_done at cycles 2, 3, 4, 5; frame_done at cycle 5.
- start with frame_len=0: remains IDLE, busy=0. Also: start asserted mid-frame is ignored and the frame is unaffected.
- clear during BETA (count=1) with stall=1: next cycle IDLE, count=0, valid=0, no pulses. rst=0 pulsed between clock edges mid-LLR: all outputs go to 0 immediately.
- CNT_W=4, L=15, BETA_DOWN=0, LLR_DOWN=1: BETA counts 0..14; LLR counts 14..0; no wrap past 14; frame_done after 60 steps.
